// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter in front of a shared bank of JK flip-flops.
// Each granted command updates one bank bit and returns a one-deep response.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  localparam int IW = $clog2(NBITS),
  localparam int RW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*IW-1:0] req_idx,
  input  logic [NREQ*2-1:0] req_jk,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RW-1:0]     rsp_id,
  output logic              rsp_q,
  output logic [NBITS-1:0]  q,
  output logic [NBITS-1:0]  q_bar
);

  logic [NBITS-1:0] q_q, q_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]    rsp_id_q, rsp_id_d;
  logic             rsp_q_q, rsp_q_d;
  logic [RW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0]  grant;
  logic [RW:0]      cand;
  logic [RW-1:0]    win;
  logic [IW-1:0]    sel_idx;
  logic [1:0]       sel_jk;
  logic             stall;
  logic             transfer;
  logic             cur_bit;
  logic             new_bit;
  logic [RW:0]      nxt_ptr;

  // An unaccepted response blocks new grants so it cannot be overwritten.
  assign stall = rsp_valid_q & ~rsp_ready;

  always_comb begin
    grant = '0;
    cand  = '0;
    if (rst_n && !stall) begin
      for (int i = 0; i < NREQ; i++) begin
        cand = {1'b0, rr_ptr_q} + (RW+1)'(i);
        if (cand >= (RW+1)'(NREQ)) cand = cand - (RW+1)'(NREQ);
        if (grant == '0 && req_valid[cand[RW-1:0]]) grant[cand[RW-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    win     = '0;
    sel_idx = '0;
    sel_jk  = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (grant[r]) begin
        win     = RW'(r);
        sel_idx = req_idx[r*IW +: IW];
        sel_jk  = req_jk[r*2 +: 2];
      end
    end
  end

  assign transfer = |grant;
  assign cur_bit  = q_q[sel_idx];
  assign nxt_ptr  = {1'b0, win} + 1'b1;

  always_comb begin
    case (sel_jk)
      2'b01:   new_bit = 1'b0;
      2'b10:   new_bit = 1'b1;
      2'b11:   new_bit = ~cur_bit;
      default: new_bit = cur_bit;
    endcase
  end

  always_comb begin
    q_d         = q_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_q_d     = rsp_q_q;
    rr_ptr_d    = rr_ptr_q;
    if (transfer) begin
      q_d[sel_idx] = new_bit;
      rsp_valid_d  = 1'b1;
      rsp_id_d     = win;
      rsp_q_d      = new_bit;
      rr_ptr_d     = (nxt_ptr == (RW+1)'(NREQ)) ? '0 : nxt_ptr[RW-1:0];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      q_q         <= q_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_q_q     <= rsp_q_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_q     = rsp_q_q;
  assign q         = q_q;
  assign q_bar     = ~q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: reference model plus response scoreboard,
// with explicit checks of the documented scenarios.
module tb_jk_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_idx;
  logic [7:0]  req_jk;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_q;
  logic [7:0]  q;
  logic [7:0]  q_bar;

  jk_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_jk(req_jk),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_q(rsp_q),
    .q(q), .q_bar(q_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // reference model state
  logic [7:0] m_q      = '0;
  int         m_rr     = 0;
  logic       m_rsp_v  = 1'b0;
  logic [2:0] sb[$];
  logic [3:0] last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input bit v, input int idx, input logic [1:0] jk);
    req_valid[r]        = v;
    req_idx[r*3 +: 3]   = idx[2:0];
    req_jk[r*2 +: 2]    = jk;
  endtask

  task automatic cycle();
    logic [3:0] exp_g;
    logic [2:0] e;
    logic [2:0] t_idx;
    logic [1:0] t_jk;
    int         c;
    int         win;
    @(negedge clk);
    exp_g = '0;
    win   = 0;
    if (rst_n && !(m_rsp_v && !rsp_ready)) begin
      for (int i = 0; i < 4; i++) begin
        c = (m_rr + i) % 4;
        if (exp_g == 4'b0 && req_valid[c]) begin
          exp_g[c] = 1'b1;
          win = c;
        end
      end
    end
    last_grant = req_ready;
    chk("grant", req_ready, exp_g);
    if (!rst_n) begin
      m_q = '0; m_rr = 0; m_rsp_v = 1'b0;
      sb.delete();
    end else if (exp_g != 4'b0) begin
      t_idx = req_idx[win*3 +: 3];
      t_jk  = req_jk[win*2 +: 2];
      case (t_jk)
        2'b01: m_q[t_idx] = 1'b0;
        2'b10: m_q[t_idx] = 1'b1;
        2'b11: m_q[t_idx] = ~m_q[t_idx];
        default: ;
      endcase
      m_rr    = (win + 1) % 4;
      m_rsp_v = 1'b1;
      sb.push_back({2'(win), m_q[t_idx]});
    end else if (rsp_ready) begin
      m_rsp_v = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("q", q, m_q);
    chk("rsp_valid", rsp_valid, m_rsp_v);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_id", rsp_id, e[2:1]);
      chk("rsp_q", rsp_q, e[0]);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] nq;
    logic [3:0] bad;
    if (chk_en) begin
      nq  = ~q;
      bad = req_ready & ~req_valid;
      chk("q_bar", q_bar, nq);
      chk("ready_onehot0", $onehot0(req_ready), 1);
      chk("ready_wo_valid", bad, 0);
    end
  end

  logic [3:0] rr_g [5];
  logic [7:0] rr_q [5];

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_idx = '0; req_jk = '0;
    rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};

    // reset state
    cycle(); cycle();
    chk_en = 1'b1;
    chk("rst_q", q, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_q", rsp_q, 0);
    rst_n = 1'b1;

    // single SET from r2
    set_req(2, 1, 5, 2'b10);
    cycle();
    chk("s1_grant", last_grant, 4'b0100);
    chk("s1_q", q, 8'h20);
    chk("s1_rsp_id", rsp_id, 2);
    chk("s1_rsp_q", rsp_q, 1);
    set_req(2, 0, 0, 2'b00);
    cycle();
    chk("s1_rsp_clear", rsp_valid, 0);

    // round-robin fairness from a fresh reset
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    for (int r = 0; r < 4; r++) set_req(r, 1, r, 2'b11);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_grant", last_grant, rr_g[k]);
      chk("rr_q", q, rr_q[k]);
    end
    req_valid = '0;
    cycle();

    // backpressure: r1 SET bit4, then stall three cycles
    set_req(1, 1, 4, 2'b10);
    cycle();
    chk("bp_first_q", q, 8'h1E);
    set_req(1, 0, 0, 2'b00);
    rsp_ready = 1'b0;
    set_req(0, 1, 6, 2'b10);
    set_req(2, 1, 1, 2'b01);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_stall_grant", last_grant, 4'b0000);
      chk("bp_stall_q", q, 8'h1E);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_resume_grant", last_grant, 4'b0100);
    chk("bp_resume_q", q, 8'h1C);
    set_req(2, 0, 0, 2'b00);
    cycle();
    chk("bp_next_grant", last_grant, 4'b0001);
    chk("bp_next_q", q, 8'h5C);
    req_valid = '0;
    cycle();

    // same-bit contention after reset
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    set_req(0, 1, 7, 2'b10);
    set_req(1, 1, 7, 2'b11);
    cycle();
    chk("sb_r0_grant", last_grant, 4'b0001);
    chk("sb_r0_rsp_q", rsp_q, 1);
    set_req(0, 0, 0, 2'b00);
    cycle();
    chk("sb_r1_grant", last_grant, 4'b0010);
    chk("sb_r1_rsp_q", rsp_q, 0);
    chk("sb_final_q7", q[7], 0);
    set_req(1, 0, 0, 2'b00);

    // HOLD from r3 with q=0x02, then rr_ptr wraps to 0
    set_req(1, 1, 1, 2'b10);
    cycle();
    chk("hold_setup_q", q, 8'h02);
    set_req(1, 0, 0, 2'b00);
    set_req(3, 1, 1, 2'b00);
    cycle();
    chk("hold_grant", last_grant, 4'b1000);
    chk("hold_rsp_q", rsp_q, 1);
    chk("hold_q", q, 8'h02);
    set_req(0, 1, 0, 2'b10);
    cycle();
    chk("hold_wrap_grant", last_grant, 4'b0001);
    chk("hold_wrap_q", q, 8'h03);

    // reset with a response pending
    set_req(0, 0, 0, 2'b00);
    set_req(1, 1, 2, 2'b10);
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_grant", last_grant, 4'b0000);
    chk("rst_mid_q", q, 8'h00);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    cycle();
    chk("rst_after_grant", last_grant, 4'b0010);
    chk("rst_after_q", q, 8'h04);
    req_valid = '0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
